// File: rtl/sc_fir_pkg.sv
// Shared SC FIR definitions: stream precision, sample type, decoder states and
// the bipolar sample conversion used by the stream decoder.
package sc_fir_pkg;

  localparam int N     = 12;
  localparam int POW2N = 1 << N;
  localparam int OUT_W = N + 1;

  typedef enum logic {IDLE = 1'b0, ACCUM = 1'b1} sc_dec_state_t;
  typedef logic [OUT_W-1:0] sc_sample_t;

  // 2*ones - 2^N evaluated at N+2 bits; only +2^N needs saturating into OUT_W bits
  function automatic sc_sample_t sc_to_bipolar(input logic [N:0] ones);
    logic [N+1:0] diff;
    diff = {ones, 1'b0} - {2'b01, {N{1'b0}}};
    if (diff == {2'b01, {N{1'b0}}}) begin
      sc_to_bipolar = {1'b0, {N{1'b1}}};
    end else begin
      sc_to_bipolar = diff[N:0];
    end
  endfunction

endpackage

// File: rtl/sc_window_counter.sv
// Accepted-bit counter for one decoding window; flags the bit that closes it.
// Counting past the closing bit wraps to zero, ready for the next window.
module sc_window_counter #(
  parameter int N = 12
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic last
);

  logic [N-1:0] count_r;

  // accepted-bit count, cleared when a window opens
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_r <= {N{1'b0}};
    end else if (clear) begin
      count_r <= {N{1'b0}};
    end else if (en) begin
      count_r <= count_r + {{(N-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  assign last = en && (count_r == {N{1'b1}});

endmodule

// File: rtl/sc_stream_decoder.sv
// Stochastic-to-binary decoder: counts ones over a 2^N-bit window and emits one sample.
// Build option SC_BIPOLAR_EN selects bipolar (two's complement) output instead of unipolar.
module sc_stream_decoder
  import sc_fir_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       in_bit,
  input  logic       in_valid,
  output logic       busy,
  output sc_sample_t out,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       overrun
);

  sc_dec_state_t state_r;
  logic          busy_r;
  logic [N:0]    ones_r;
  sc_sample_t    out_r;
  logic          out_valid_r;
  logic          overrun_r;

  logic          start_win_s;
  logic          acc_en_s;
  logic          last_s;
  logic [N:0]    ones_next_s;
  sc_sample_t    result_s;

  sc_window_counter #(.N(N)) u_win (
    .clock (clock),
    .reset (reset),
    .clear (start_win_s),
    .en    (acc_en_s),
    .last  (last_s)
  );

  // window control and the closing bit's contribution to the result
  always_comb begin
    start_win_s = (state_r == IDLE) && start;
    acc_en_s    = (state_r == ACCUM) && in_valid;
    ones_next_s = ones_r + {{N{1'b0}}, in_bit};
`ifdef SC_BIPOLAR_EN
    result_s    = sc_to_bipolar(ones_next_s);
`else
    result_s    = ones_next_s;
`endif
  end

  // window FSM; busy registered alongside the state
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            state_r <= ACCUM;
            busy_r  <= 1'b1;
          end else begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end
        end
        ACCUM: begin
          if (last_s) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end else begin
            state_r <= ACCUM;
            busy_r  <= 1'b1;
          end
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  // ones counter; at most 2^N by window close, so N+1 bits never wrap
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ones_r <= {(N+1){1'b0}};
    end else if (start_win_s) begin
      ones_r <= {(N+1){1'b0}};
    end else if (acc_en_s) begin
      ones_r <= ones_next_s;
    end else begin
      ones_r <= ones_r;
    end
  end

  // output register: a new load beats a same-edge consume
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_r       <= {OUT_W{1'b0}};
      out_valid_r <= 1'b0;
      overrun_r   <= 1'b0;
    end else if (last_s) begin
      out_r       <= result_s;
      out_valid_r <= 1'b1;
      if (out_valid_r && !out_ready) begin
        overrun_r <= 1'b1;
      end else begin
        overrun_r <= overrun_r;
      end
    end else if (out_valid_r && out_ready) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

  assign busy      = busy_r;
  assign out       = out_r;
  assign out_valid = out_valid_r;
  assign overrun   = overrun_r;

endmodule

// File: tb/tb_sc_stream_decoder.sv
// Self-checking bench for sc_stream_decoder: vector table of whole windows, random
// stream/stall patterns, and hand sequences for overrun, load-wins and mid-window reset.
module tb_sc_stream_decoder;

  localparam int WIN = 4096;

  logic        clock;
  logic        reset;
  logic        start;
  logic        in_bit;
  logic        in_valid;
  logic        busy_s;
  logic [12:0] out_s;
  logic        out_valid_s;
  logic        out_ready;
  logic        overrun_s;

  int tests;
  int fails;

  // reference model of the visible outputs
  bit          m_busy;
  bit          m_valid;
  bit          m_ovr;
  logic [12:0] m_out;

  sc_stream_decoder dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .in_bit    (in_bit),
    .in_valid  (in_valid),
    .busy      (busy_s),
    .out       (out_s),
    .out_valid (out_valid_s),
    .out_ready (out_ready),
    .overrun   (overrun_s)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    int mode;      // 0 ones, 1 zeros, 2 alternating, 3 first-K ones, 4 random with P% ones
    int param;
    int vpct;      // in_valid probability in percent
    bit mid_start;
    int exp_ones;  // -1: take the model's count
  } vec_t;

  function automatic logic [12:0] conv(input int ones);
    int v;
`ifdef SC_BIPOLAR_EN
    v = 2 * ones - WIN;
    if (v > WIN - 1) v = WIN - 1;
`else
    v = ones;
`endif
    return v[12:0];
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // advance one clock with the currently driven inputs, then compare against the model
  task automatic tick(input bit close, input logic [12:0] res);
    if (m_busy && close) m_busy = 1'b0;
    else if (!m_busy && start) m_busy = 1'b1;
    if (close) begin
      if (m_valid && !out_ready) m_ovr = 1'b1;
      m_valid = 1'b1;
      m_out   = res;
    end else if (m_valid && out_ready) begin
      m_valid = 1'b0;
    end
    @(negedge clock);
    chk("busy", 32'(busy_s), 32'(m_busy));
    chk("out_valid", 32'(out_valid_s), 32'(m_valid));
    chk("overrun", 32'(overrun_s), 32'(m_ovr));
    chk("out", 32'(out_s), 32'(m_out));
  endtask

  task automatic run_window(input int mode, input int param, input int vpct, input bit mid_start,
                            input bit rdy, input bit rdy_last, input int stop_after,
                            output int ones);
    int acc;
    int guard;
    bit v;
    bit b;
    bit fin;
    start     = 1'b1;
    in_valid  = 1'($urandom % 2);
    in_bit    = 1'($urandom % 2);
    out_ready = rdy;
    tick(1'b0, 13'h0000);
    start = 1'b0;
    acc   = 0;
    ones  = 0;
    guard = 0;
    while (acc < WIN && acc < stop_after && guard < 20000) begin
      v = ($urandom_range(99) < vpct);
      case (mode)
        0: b = 1'b1;
        1: b = 1'b0;
        2: b = (acc % 2 == 0);
        3: b = (acc < param);
        default: b = ($urandom_range(99) < param);
      endcase
      in_valid  = v;
      in_bit    = v ? b : 1'($urandom % 2);
      start     = mid_start ? ($urandom_range(7) == 0) : 1'b0;
      fin       = v && (acc == WIN - 1);
      out_ready = fin ? rdy_last : rdy;
      if (v) begin
        acc++;
        ones += int'(b);
      end
      tick(fin, conv(ones));
      guard++;
    end
    if (guard >= 20000) chk("window_timeout", 32'(guard), 32'(0));
    in_valid  = 1'b0;
    start     = 1'b0;
    out_ready = rdy;
  endtask

  vec_t vecs[6];

  initial begin
    int ones;
    tests = 0;
    fails = 0;
    vecs[0] = '{0, 0, 100, 1'b0, 4096};
    vecs[1] = '{1, 0, 100, 1'b0, 0};
    vecs[2] = '{2, 0, 100, 1'b0, 2048};
    vecs[3] = '{0, 0, 50, 1'b1, 4096};
    vecs[4] = '{4, 30, 70, 1'b0, -1};
    vecs[5] = '{4, 80, 90, 1'b1, -1};

    reset = 1'b1; start = 1'b0; in_bit = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    m_busy = 1'b0; m_valid = 1'b0; m_ovr = 1'b0; m_out = 13'h0000;
    repeat (3) @(negedge clock);
    chk("rst_busy", 32'(busy_s), 32'(0));
    chk("rst_out_valid", 32'(out_valid_s), 32'(0));
    chk("rst_out", 32'(out_s), 32'(0));
    reset = 1'b0;
    tick(1'b0, 13'h0000);
    // in_bit ignored while idle
    in_valid = 1'b1; in_bit = 1'b1;
    repeat (4) tick(1'b0, 13'h0000);

    for (int i = 0; i < 6; i++) begin
      run_window(vecs[i].mode, vecs[i].param, vecs[i].vpct, vecs[i].mid_start, 1'b1, 1'b1, WIN, ones);
      chk($sformatf("vec%0d", i), 32'(out_s),
          32'(conv(vecs[i].exp_ones < 0 ? ones : vecs[i].exp_ones)));
      tick(1'b0, 13'h0000);
    end

    // pending result, then a new load on the same edge as the consume: no overrun
    reset = 1'b1; #2; reset = 1'b0;
    m_busy = 1'b0; m_valid = 1'b0; m_ovr = 1'b0; m_out = 13'h0000;
    run_window(3, 100, 100, 1'b0, 1'b0, 1'b0, WIN, ones);
    run_window(3, 200, 100, 1'b0, 1'b0, 1'b1, WIN, ones);
    chk("loadwins_out", 32'(out_s), 32'(conv(200)));
    chk("loadwins_ovr", 32'(overrun_s), 32'(0));
    out_ready = 1'b1;
    tick(1'b0, 13'h0000);

    // two results without a consume: overrun sticks through a later consume
    run_window(3, 1024, 100, 1'b0, 1'b0, 1'b0, WIN, ones);
    chk("ovr_first", 32'(overrun_s), 32'(0));
    run_window(3, 3072, 100, 1'b0, 1'b0, 1'b0, WIN, ones);
    chk("ovr_out", 32'(out_s), 32'(conv(3072)));
    chk("ovr_set", 32'(overrun_s), 32'(1));
    out_ready = 1'b1;
    tick(1'b0, 13'h0000);
    out_ready = 1'b0;
    tick(1'b0, 13'h0000);
    chk("ovr_consumed", 32'(out_valid_s), 32'(0));
    chk("ovr_sticky", 32'(overrun_s), 32'(1));

    // asynchronous reset mid-window discards the partial count
    out_ready = 1'b1;
    run_window(0, 0, 100, 1'b0, 1'b1, 1'b1, 1000, ones);
    in_valid = 1'b1; in_bit = 1'b1;
    #2 reset = 1'b1;
    #1;
    m_busy = 1'b0; m_valid = 1'b0; m_ovr = 1'b0; m_out = 13'h0000;
    chk("midrst_busy", 32'(busy_s), 32'(0));
    chk("midrst_valid", 32'(out_valid_s), 32'(0));
    chk("midrst_out", 32'(out_s), 32'(0));
    chk("midrst_ovr", 32'(overrun_s), 32'(0));
    @(negedge clock);
    reset = 1'b0;
    in_valid = 1'b0;
    run_window(3, 512, 100, 1'b0, 1'b1, 1'b1, WIN, ones);
    chk("after_rst", 32'(out_s), 32'(conv(512)));
    tick(1'b0, 13'h0000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
